dft_mag_buffer: RTL and testbench
=================================

Name: dft_mag_buffer

Overview:
- Sits directly downstream of the 24-point DFT core. Consumes its natural-order XK_RE/XK_IM stream, along with DATA_VALID, FD_OUT and BLK_EXP.
- Converts each bin to an approximate magnitude and stores one complete frame in a ping-pong buffer.
- Tracks the per-frame peak bin.
- Provides a random-access read port and a frame_ready/rd_ack handshake for the display/CPU side.

Parameters:
- BINS, 24, bins per frame.
- DW, 18, signed width of xk_re/xk_im.
- MW, 18, unsigned magnitude width.
- AW, 5, bin address width.
- SKIP_DC, 1, when 1 bin 0 is excluded from peak search.

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- xk_re, in, DW, signed real bin value from DFT.
- xk_im, in, DW, signed imaginary bin value from DFT.
- blk_exp, in, 4, DFT block exponent.
- fd_out, in, 1, high with data_valid on the first (bin 0) sample of a frame.
- data_valid, in, 1, current xk_re/xk_im valid.
- rd_addr, in, AW, read bin address.
- rd_ack, in, 1, one-cycle pulse: reader finished with the current frame.
- err_clr, in, 1, clears sticky error flags.
- rd_data, out, MW, magnitude at rd_addr (registered).
- frame_exp, out, 4, blk_exp of the committed frame.
- peak_bin, out, AW, bin index of the largest magnitude.
- peak_mag, out, MW, magnitude of peak_bin.
- frame_ready, out, 1, committed frame available.
- frame_count, out, 8, committed frames, wraps 255->0.
- overrun, out, 1, sticky: frame committed while frame_ready was still high.
- short_frame, out, 1, sticky: fd_out arrived before BINS samples.

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0.
  - Write bank = 0; bank_valid = 0; FSM = IDLE; bin counter = 0.
  - RAM contents are not reset.
- Stage 1 (edge sampling data_valid=1): register |re|, |im| as MW-bit unsigned, plus the bin index and a last flag. |-131072| = 131072, no saturation.
- Stage 2 (next edge):
  - mag = max + (min>>2) + (min>>3), truncated shifts. Maximum is 180224, which fits MW.
  - Write mag to write bank[bin].
  - Peak update if mag > running peak, strict, so the lowest bin wins ties. Bin 0 is skipped when SKIP_DC=1.
- Write FSM:
  - IDLE: data_valid without fd_out is ignored. fd_out&data_valid → capture blk_exp, bin=0 → COLLECT.
  - COLLECT: each data_valid increments bin. Gaps in data_valid are allowed.
  - COLLECT, fd_out&data_valid at bin != 0: set short_frame, discard the partial frame, restart at bin 0 with the new blk_exp.
  - COLLECT, sample with bin = BINS-1: → COMMIT once stage 2 has written it.
  - COMMIT (one cycle, the edge after the last RAM write):
    - Swap banks; bank_valid=1.
    - Load frame_exp, peak_bin, peak_mag.
    - frame_count+1; frame_ready=1.
    - Clear the running peak → IDLE.
- Commit latency: frame_ready is high after the 3rd rising edge following the edge that samples bin BINS-1.
- A new fd_out is accepted in the COMMIT cycle only from the following cycle. The upstream DFT never produces one that early.
- Read port:
  - rd_data is registered, 1-cycle latency, from the read bank (the last committed one).
  - Returns 0 if rd_addr >= BINS or bank_valid=0.
  - Read data and peak outputs change only at COMMIT.
- Handshake:
  - rd_ack clears frame_ready.
  - COMMIT while frame_ready=1 and no rd_ack in the same cycle: overrun=1, new frame replaces old (newest wins), frame_ready stays 1.
  - COMMIT and rd_ack in the same cycle: frame_ready stays 1, no overrun.
  - rd_ack while frame_ready=0 is ignored.
- Errors: err_clr clears overrun and short_frame. If err_clr coincides with a setting event, the set wins.
- Reset mid-frame: partial frame dropped, nothing committed, previous bank contents become invalid (bank_valid=0).

Test Plan:
- Frame of 24 samples, re=1000 im=0 except bin 3 re=-4000 im=3000:
  - rd_data bins 0,1,2,4..23 = 1000; bin 3 = 5125.
  - peak_bin=3, peak_mag=5125, frame_count=1, frame_ready after 3 edges past bin 23.
  - rd_ack → frame_ready=0.
- Bin 5 re=-131072 im=-131072, others 0: rd_data[5]=180224, peak_bin=5. With SKIP_DC=1 and bin 0 = 200000-equivalent large: peak stays 5.
- fd_out reasserted at bin 10, then 24 clean samples of value 7: short_frame=1, one commit only, all bins = 7, frame_count=1. err_clr → short_frame=0.
- Two frames (values 100, then 200) without rd_ack: overrun=1, frame_count=2, rd_data reads 200. Repeat with rd_ack in the COMMIT cycle: overrun stays 0, frame_ready=1.
- data_valid gapped 1-on/2-off across 24 samples: identical RAM contents to the gap-free run. rd_addr=24..31 → rd_data=0.
- rst_n low at bin 12 of the 2nd frame: all outputs 0, rd_data=0 for all addresses. The next complete frame commits with frame_count=1.

Source files
------------

// File: rtl/dft_mag_buffer_if.sv
// dft_mag_buffer_if: DFT bin stream and blk_exp in; magnitude read port, peak and status out.
interface dft_mag_buffer_if #(
    parameter int DW = 18,
    parameter int MW = 18,
    parameter int AW = 5
);
    logic signed [DW-1:0] xk_re;
    logic signed [DW-1:0] xk_im;
    logic [3:0]           blk_exp;
    logic                 fd_out;
    logic                 data_valid;
    logic [AW-1:0]        rd_addr;
    logic                 rd_ack;
    logic                 err_clr;
    logic [MW-1:0]        rd_data;
    logic [3:0]           frame_exp;
    logic [AW-1:0]        peak_bin;
    logic [MW-1:0]        peak_mag;
    logic                 frame_ready;
    logic [7:0]           frame_count;
    logic                 overrun;
    logic                 short_frame;
    modport master (
        output xk_re, xk_im, blk_exp, fd_out, data_valid, rd_addr, rd_ack, err_clr,
        input  rd_data, frame_exp, peak_bin, peak_mag, frame_ready, frame_count, overrun, short_frame
    );
    modport slave (
        input  xk_re, xk_im, blk_exp, fd_out, data_valid, rd_addr, rd_ack, err_clr,
        output rd_data, frame_exp, peak_bin, peak_mag, frame_ready, frame_count, overrun, short_frame
    );
endinterface

// File: rtl/dft_mag_buffer.sv
// dft_mag_buffer: per-bin approximate magnitude of a DFT frame, ping-pong buffered with peak tracking.
module dft_mag_buffer #(
    parameter int BINS    = 24,
    parameter int DW      = 18,
    parameter int MW      = 18,
    parameter int AW      = 5,
    parameter bit SKIP_DC = 1'b1
) (
    input logic             clk,
    input logic             rst_n,
    dft_mag_buffer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, WAIT, COMMIT} state_t;
    state_t        state_q;
    logic [MW-1:0] mem_q [2][BINS];
    logic [AW-1:0] cnt_q, s1_bin_q, pk_bin_q, peak_bin_q;
    logic [MW-1:0] s1_re_q, s1_im_q, pk_mag_q, peak_mag_q, rd_data_q;
    logic [3:0]    exp_q, frame_exp_q;
    logic [7:0]    frame_count_q;
    logic          s1_v_q, s1_last_q, last_wr_q, wr_bank_q, bank_valid_q;
    logic          frame_ready_q, overrun_q, short_q;
    logic          accept, start, restart, last, commit, pk_upd;
    logic [MW-1:0] re_abs, im_abs, mx, mn, mag;
    always_comb begin
        accept  = bus.data_valid && (state_q == COLLECT || (state_q == IDLE && bus.fd_out));
        start   = accept && bus.fd_out;
        restart = start && state_q == COLLECT;
        last    = !start && cnt_q == AW'(BINS - 1);
        commit  = state_q == COMMIT;
        re_abs  = MW'($unsigned(bus.xk_re[DW-1] ? -bus.xk_re : bus.xk_re));
        im_abs  = MW'($unsigned(bus.xk_im[DW-1] ? -bus.xk_im : bus.xk_im));
        mx      = s1_re_q > s1_im_q ? s1_re_q : s1_im_q;
        mn      = s1_re_q > s1_im_q ? s1_im_q : s1_re_q;
        mag     = mx + (mn >> 2) + (mn >> 3);
        pk_upd  = s1_v_q && !(SKIP_DC && s1_bin_q == '0) && mag > pk_mag_q;
    end
    // Magnitude RAM is deliberately left out of reset; bank_valid_q masks stale contents.
    always_ff @(posedge clk) begin
        if (s1_v_q) mem_q[wr_bank_q][s1_bin_q] <= mag;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            s1_v_q        <= 1'b0;
            s1_last_q     <= 1'b0;
            s1_bin_q      <= '0;
            s1_re_q       <= '0;
            s1_im_q       <= '0;
            last_wr_q     <= 1'b0;
            exp_q         <= '0;
            pk_mag_q      <= '0;
            pk_bin_q      <= '0;
            wr_bank_q     <= 1'b0;
            bank_valid_q  <= 1'b0;
            frame_exp_q   <= '0;
            peak_bin_q    <= '0;
            peak_mag_q    <= '0;
            frame_count_q <= '0;
            frame_ready_q <= 1'b0;
            overrun_q     <= 1'b0;
            short_q       <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            s1_v_q    <= accept;
            last_wr_q <= s1_v_q && s1_last_q;
            if (accept) begin
                s1_re_q   <= re_abs;
                s1_im_q   <= im_abs;
                s1_bin_q  <= start ? '0 : cnt_q;
                s1_last_q <= last;
                cnt_q     <= start ? AW'(1) : last ? '0 : cnt_q + 1'b1;
            end
            if (start) exp_q <= bus.blk_exp;
            state_q <= accept ? (last ? WAIT : COLLECT) :
                       (state_q == WAIT && last_wr_q) ? COMMIT :
                       commit ? IDLE : state_q;
            // A restart also discards the in-flight sample of the abandoned frame.
            if (restart || commit) begin
                pk_mag_q <= '0;
                pk_bin_q <= '0;
            end else if (pk_upd) begin
                pk_mag_q <= mag;
                pk_bin_q <= s1_bin_q;
            end
            if (commit) begin
                wr_bank_q     <= ~wr_bank_q;
                bank_valid_q  <= 1'b1;
                frame_exp_q   <= exp_q;
                peak_bin_q    <= pk_bin_q;
                peak_mag_q    <= pk_mag_q;
                frame_count_q <= frame_count_q + 8'd1;
            end
            frame_ready_q <= commit || (frame_ready_q && !bus.rd_ack);
            overrun_q     <= (commit && frame_ready_q && !bus.rd_ack) || (overrun_q && !bus.err_clr);
            short_q       <= restart || (short_q && !bus.err_clr);
            rd_data_q     <= (bank_valid_q && 32'(bus.rd_addr) < BINS) ? mem_q[~wr_bank_q][bus.rd_addr] : '0;
        end
    end
    assign bus.rd_data     = rd_data_q;
    assign bus.frame_exp   = frame_exp_q;
    assign bus.peak_bin    = peak_bin_q;
    assign bus.peak_mag    = peak_mag_q;
    assign bus.frame_ready = frame_ready_q;
    assign bus.frame_count = frame_count_q;
    assign bus.overrun     = overrun_q;
    assign bus.short_frame = short_q;
endmodule

// File: tb/tb_dft_mag_buffer.sv
// tb_dft_mag_buffer: directed and randomized frames checked every cycle against a frame-level model.
module tb_dft_mag_buffer;
    localparam int BINS = 24;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dft_mag_buffer_if #(.DW(18), .MW(18), .AW(5)) bus ();
    dft_mag_buffer #(.BINS(BINS), .DW(18), .MW(18), .AW(5), .SKIP_DC(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_chk = 0, n_fail = 0;
    bit chk_en = 0, rnd_addr = 1, rnd_hs = 0;
    int m_buf[BINS], c_mag[BINS], fr_re[BINS], fr_im[BINS];
    int m_idx = 0, cd = 0, m_exp = 0, c_exp = 0, c_pb = 0, c_pm = 0, c_cnt = 0, e_rd = 0;
    bit m_act = 0, c_valid = 0, c_ready = 0, c_over = 0, c_short = 0;

    function automatic int mag_of(input int re, input int im);
        int a, b, mx, mn;
        a = re < 0 ? -re : re;
        b = im < 0 ? -im : im;
        mx = a > b ? a : b;
        mn = a > b ? b : a;
        return mx + mn / 4 + mn / 8;
    endfunction

    task automatic cmp(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: samples collected into a frame array, committed three edges after the last one.
    initial forever begin
        bit sf, ov, com;
        int mg;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_act = 0; m_idx = 0; cd = 0; c_valid = 0; c_ready = 0; c_over = 0; c_short = 0;
            c_cnt = 0; c_exp = 0; c_pb = 0; c_pm = 0; e_rd = 0;
        end else begin
            sf = 0; ov = 0; com = 0;
            e_rd = (c_valid && bus.rd_addr < BINS) ? c_mag[bus.rd_addr] : 0;
            if (cd > 0) begin
                cd--;
                com = (cd == 0);
            end else if (bus.data_valid && (bus.fd_out || m_act)) begin
                mg = mag_of(int'(bus.xk_re), int'(bus.xk_im));
                if (bus.fd_out) begin
                    sf = m_act; m_act = 1; m_idx = 0; m_exp = int'(bus.blk_exp);
                end
                m_buf[m_idx] = mg;
                m_idx++;
                if (m_idx == BINS) begin m_act = 0; cd = 3; end
            end
            if (com) begin
                c_mag = m_buf; c_valid = 1; c_exp = m_exp; c_pb = 0; c_pm = 0;
                for (int b = 1; b < BINS; b++) if (m_buf[b] > c_pm) begin c_pm = m_buf[b]; c_pb = b; end
                c_cnt = (c_cnt + 1) % 256;
                ov = c_ready && !bus.rd_ack;
                c_ready = 1;
            end else if (bus.rd_ack) c_ready = 0;
            c_over  = ov || (c_over && !bus.err_clr);
            c_short = sf || (c_short && !bus.err_clr);
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            cmp("rd_data", bus.rd_data, e_rd);
            cmp("frame_exp", bus.frame_exp, c_exp);
            cmp("peak_bin", bus.peak_bin, c_pb);
            cmp("peak_mag", bus.peak_mag, c_pm);
            cmp("frame_ready", bus.frame_ready, c_ready);
            cmp("frame_count", bus.frame_count, c_cnt);
            cmp("overrun", bus.overrun, c_over);
            cmp("short_frame", bus.short_frame, c_short);
        end
    end

    task automatic step(input bit dv, input bit fd, input int re, input int im, input int ex);
        bus.data_valid = dv;
        bus.fd_out = fd;
        bus.xk_re = 18'(re);
        bus.xk_im = 18'(im);
        bus.blk_exp = 4'(ex);
        if (rnd_addr) bus.rd_addr = 5'($urandom_range(0, 31));
        if (rnd_hs) begin
            bus.rd_ack = ($urandom_range(0, 7) == 0);
            bus.err_clr = ($urandom_range(0, 15) == 0);
        end
        @(posedge clk);
        #2;
        bus.data_valid = 0; bus.fd_out = 0; bus.rd_ack = 0; bus.err_clr = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic send(input int gap, input int ex);
        for (int i = 0; i < BINS; i++) begin
            step(1, i == 0, fr_re[i], fr_im[i], i == 0 ? ex : int'($urandom_range(0, 15)));
            if (i < BINS - 1) idle(gap < 0 ? int'($urandom_range(0, 2)) : gap);
        end
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < BINS; i++) begin fr_re[i] = v; fr_im[i] = 0; end
    endtask

    task automatic randfill();
        for (int i = 0; i < BINS; i++) begin
            fr_re[i] = int'($urandom_range(0, 262143)) - 131072;
            fr_im[i] = int'($urandom_range(0, 262143)) - 131072;
        end
    endtask

    task automatic rdchk(input string name, input int a, input int e);
        bit s;
        s = rnd_addr;
        rnd_addr = 0;
        bus.rd_addr = 5'(a);
        step(0, 0, 0, 0, 0);
        cmp(name, bus.rd_data, e);
        rnd_addr = s;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bus.data_valid = 0; bus.fd_out = 0; bus.xk_re = 0; bus.xk_im = 0; bus.blk_exp = 0;
        bus.rd_addr = 0; bus.rd_ack = 0; bus.err_clr = 0;
        #3 rst_n = 0;
        chk_en = 1;
        repeat (2) @(posedge clk);
        #2;
        cmp("reset_ready", bus.frame_ready, 0);
        cmp("reset_count", bus.frame_count, 0);
        cmp("reset_peak_mag", bus.peak_mag, 0);
        cmp("reset_rd_data", bus.rd_data, 0);
        rst_n = 1;
        idle(2);
        fill(1000); fr_re[3] = -4000; fr_im[3] = 3000;
        send(0, 9);
        idle(2);
        cmp("t1_ready_edge2", bus.frame_ready, 0);
        idle(1);
        cmp("t1_ready_edge3", bus.frame_ready, 1);
        cmp("t1_peak_bin", bus.peak_bin, 3);
        cmp("t1_peak_mag", bus.peak_mag, 5125);
        cmp("t1_count", bus.frame_count, 1);
        cmp("t1_exp", bus.frame_exp, 9);
        rdchk("t1_bin3", 3, 5125);
        rdchk("t1_bin0", 0, 1000);
        rdchk("t1_bin23", 23, 1000);
        bus.rd_ack = 1; idle(1);
        cmp("t1_ack", bus.frame_ready, 0);
        fill(0); fr_re[5] = -131072; fr_im[5] = -131072; fr_re[0] = -131072; fr_im[0] = -131072;
        send(0, 3); idle(3);
        cmp("t2_peak_bin", bus.peak_bin, 5);
        cmp("t2_peak_mag", bus.peak_mag, 180224);
        rdchk("t2_bin5", 5, 180224);
        rdchk("t2_bin0", 0, 180224);
        rdchk("t2_bin4", 4, 0);
        bus.rd_ack = 1; idle(1);
        for (int i = 0; i < 10; i++) step(1, i == 0, 50, -50, 1);
        fill(7);
        send(0, 6); idle(3);
        cmp("t3_short", bus.short_frame, 1);
        cmp("t3_count", bus.frame_count, 3);
        cmp("t3_peak_bin", bus.peak_bin, 1);
        cmp("t3_peak_mag", bus.peak_mag, 7);
        cmp("t3_exp", bus.frame_exp, 6);
        rdchk("t3_bin9", 9, 7);
        rdchk("t3_bin12", 12, 7);
        bus.err_clr = 1; bus.rd_ack = 1; idle(1);
        cmp("t3_err_clr", bus.short_frame, 0);
        fill(100); send(0, 1); idle(3);
        fill(200); send(0, 2); idle(3);
        cmp("t4_overrun", bus.overrun, 1);
        cmp("t4_count", bus.frame_count, 5);
        cmp("t4_ready", bus.frame_ready, 1);
        rdchk("t4_bin7", 7, 200);
        bus.err_clr = 1; bus.rd_ack = 1; idle(1);
        cmp("t4_overrun_clr", bus.overrun, 0);
        fill(100); send(0, 1); idle(3);
        fill(200); send(0, 2); idle(2);
        bus.rd_ack = 1; idle(1);
        cmp("t4_ack_commit_overrun", bus.overrun, 0);
        cmp("t4_ack_commit_ready", bus.frame_ready, 1);
        cmp("t4_ack_commit_count", bus.frame_count, 7);
        randfill();
        send(0, 4); idle(3);
        bus.rd_ack = 1; idle(1);
        send(2, 4); idle(3);
        for (int a = 0; a < 32; a++) rdchk("t5_gapped_rd", a, a < BINS ? mag_of(fr_re[a], fr_im[a]) : 0);
        cmp("t5_count", bus.frame_count, 9);
        rnd_hs = 1;
        repeat (6) begin
            randfill();
            send(-1, int'($urandom_range(0, 15)));
            idle(int'($urandom_range(3, 6)));
        end
        rnd_hs = 0;
        bus.rd_ack = 1; idle(1);
        randfill();
        send(0, 5); idle(3);
        for (int i = 0; i < 12; i++) step(1, i == 0, fr_re[i], fr_im[i], 5);
        rst_n = 0;
        #1;
        cmp("t7_rst_rd_data", bus.rd_data, 0);
        cmp("t7_rst_ready", bus.frame_ready, 0);
        cmp("t7_rst_count", bus.frame_count, 0);
        cmp("t7_rst_peak_mag", bus.peak_mag, 0);
        cmp("t7_rst_exp", bus.frame_exp, 0);
        idle(2);
        rst_n = 1;
        for (int a = 0; a < 32; a++) rdchk("t7_invalid_rd", a, 0);
        send(0, 7); idle(3);
        cmp("t7_count", bus.frame_count, 1);
        cmp("t7_ready", bus.frame_ready, 1);
        rdchk("t7_bin0", 0, mag_of(fr_re[0], fr_im[0]));
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
